// File: rtl/run_burst_pkg.sv
// Shared types and helpers for the serial run-length burst generator.
package run_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Width needed to hold gap counts 0..gap_len-1, never narrower than one bit.
  function automatic int gap_cnt_w(input int gap_len);
    return (gap_len < 1) ? 1 : $clog2(gap_len + 1);
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that saturates at zero; load takes priority over decrement.
module load_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/run_burst_generator.sv
// Drives a run of req_len 1s followed by GAP_LEN 0s per accepted request,
// flagging the end of long runs (eor) and the last gap bit (done).
module run_burst_generator
  import run_burst_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int GAP_LEN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  output logic             c,
  output logic             busy,
  output logic             eor,
  output logic             done
);

  localparam int            GW       = gap_cnt_w(GAP_LEN);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LEN - 1);

  if (LEN_W < 2) begin : g_chk_len_w
    $error("run_burst_generator: LEN_W must be at least 2");
  end
  if (GAP_LEN < 1) begin : g_chk_gap_len
    $error("run_burst_generator: GAP_LEN must be at least 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic             r_long;
  logic             w_accept;
  logic             w_len_nz;
  logic             w_run_load;
  logic             w_run_dec;
  logic             w_run_zero;
  logic [LEN_W-1:0] w_unused_run_cnt;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic             w_gap_zero;
  logic [GW-1:0]    w_gap_cnt;

  assign w_accept   = req_valid && req_ready;
  assign w_len_nz   = (req_len != '0);
  assign w_run_load = w_accept && w_len_nz;
  assign w_run_dec  = (r_state == RUN);
  // The gap starts either from a zero-length request or from the last run bit.
  assign w_gap_load = (w_accept && !w_len_nz) || ((r_state == RUN) && w_run_zero);
  assign w_gap_dec  = (r_state == GAP);

  load_down_counter #(.WIDTH(LEN_W)) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_run_load),
    .load_val (req_len - LEN_W'(1)),
    .dec      (w_run_dec),
    .count    (w_unused_run_cnt),
    .zero     (w_run_zero)
  );

  load_down_counter #(.WIDTH(GW)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_gap_load),
    .load_val (GAP_LOAD),
    .dec      (w_gap_dec),
    .count    (w_gap_cnt),
    .zero     (w_gap_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_long  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_long <= (req_len >= LEN_W'(2));
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_len_nz ? RUN : GAP;
      RUN:  if (w_run_zero) w_next = GAP;
      GAP: begin
        if (w_gap_zero) begin
          if (w_accept) w_next = w_len_nz ? RUN : GAP;
          else          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE) || ((r_state == GAP) && w_gap_zero);
    c         = (r_state == RUN);
    busy      = (r_state != IDLE);
    eor       = (r_state == GAP) && (w_gap_cnt == GAP_LOAD) && r_long;
    done      = (r_state == GAP) && w_gap_zero;
  end

endmodule

// File: tb/tb_run_burst_generator.sv
// Bench for run_burst_generator: GAP_LEN=1 and GAP_LEN=3 instances checked
// every cycle against a queue-of-bits model, plus literal expectations.
module tb_run_burst_generator;

  typedef struct packed {
    logic c;
    logic eor;
    logic done;
  } ent_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       vld [2];
  logic [3:0] len [2];
  logic       d_rdy [2];
  logic       d_c [2];
  logic       d_busy [2];
  logic       d_eor [2];
  logic       d_done [2];

  int   gaps [2];
  ent_t q0 [$];
  ent_t q1 [$];
  bit   acc [2];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit          tr_en  = 1'b0;
  int          tr_sel = 0;
  int          tr_n;
  logic [63:0] tr_c, tr_e, tr_d;

  always #5 clk = ~clk;

  run_burst_generator #(.LEN_W(4), .GAP_LEN(1)) u_g1 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_len(len[0]),
    .req_ready(d_rdy[0]), .c(d_c[0]), .busy(d_busy[0]), .eor(d_eor[0]), .done(d_done[0])
  );

  run_burst_generator #(.LEN_W(4), .GAP_LEN(3)) u_g3 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_len(len[1]),
    .req_ready(d_rdy[1]), .c(d_c[1]), .busy(d_busy[1]), .eor(d_eor[1]), .done(d_done[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A request becomes len ones then gaps zeros; eor on the first zero of a
  // long run, done on the last zero. Ready whenever the shown bit is a done.
  function automatic void burst(input int l, input int g, inout ent_t q[$]);
    ent_t e;
    for (int i = 0; i < l; i++) begin
      e = '{c: 1'b1, eor: 1'b0, done: 1'b0};
      q.push_back(e);
    end
    for (int j = 0; j < g; j++) begin
      e.c    = 1'b0;
      e.eor  = (j == 0) && (l >= 2);
      e.done = (j == g - 1);
      q.push_back(e);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    ent_t e;
    bit   rdy;
    if (!reset) begin
      q0.delete();
      q1.delete();
      acc[0] = 1'b0;
      acc[1] = 1'b0;
    end else begin
      rdy    = (q0.size() == 0) || q0[0].done;
      acc[0] = vld[0] && rdy;
      if (q0.size() != 0) void'(q0.pop_front());
      if (acc[0]) burst(int'(len[0]), gaps[0], q0);
      rdy    = (q1.size() == 0) || q1[0].done;
      acc[1] = vld[1] && rdy;
      if (q1.size() != 0) void'(q1.pop_front());
      if (acc[1]) burst(int'(len[1]), gaps[1], q1);
    end
    #1;
    e = (q0.size() != 0) ? q0[0] : '0;
    chk("cyc_gap1", {d_rdy[0], d_c[0], d_busy[0], d_eor[0], d_done[0]},
        {(q0.size() == 0) || e.done, e.c, q0.size() != 0, e.eor, e.done});
    e = (q1.size() != 0) ? q1[0] : '0;
    chk("cyc_gap3", {d_rdy[1], d_c[1], d_busy[1], d_eor[1], d_done[1]},
        {(q1.size() == 0) || e.done, e.c, q1.size() != 0, e.eor, e.done});
    if (!tr_en) begin
      tr_n = 0;
      tr_c = '0;
      tr_e = '0;
      tr_d = '0;
    end else begin
      tr_c = {tr_c[62:0], d_c[tr_sel]};
      tr_e = {tr_e[62:0], d_eor[tr_sel]};
      tr_d = {tr_d[62:0], d_done[tr_sel]};
      tr_n++;
    end
  end

  // Present a request and hold it until the model sees it accepted.
  task automatic send(input int k, input int l);
    bit ok;
    ok     = 1'b0;
    vld[k] = 1'b1;
    len[k] = 4'(l);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (acc[k]) ok = 1'b1;
    end
    vld[k] = 1'b0;
    len[k] = 4'hA;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    gaps[0] = 1;
    gaps[1] = 3;
    vld[0]  = 1'b0;
    vld[1]  = 1'b0;
    len[0]  = 4'd0;
    len[1]  = 4'd0;

    cycles(3);
    chk("rst_hold", {d_rdy[0], d_c[0], d_busy[0], d_eor[0], d_done[0]}, 5'b10000);
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    chk("rst_release", {d_rdy[0], d_busy[0], d_rdy[1], d_busy[1]}, 4'b1010);

    send(0, 3);
    chk("len3_first", d_c[0], 1'b1);
    cycles(1);
    chk("len3_second", d_c[0], 1'b1);
    cycles(1);
    chk("len3_third", d_c[0], 1'b1);
    cycles(1);
    chk("len3_gap", {d_c[0], d_eor[0], d_done[0], d_rdy[0]}, 4'b0111);
    cycles(1);
    chk("len3_idle", d_busy[0], 1'b0);
    cycles(2);

    tr_sel = 0;
    tr_en  = 1'b1;
    send(0, 1);
    send(0, 0);
    tr_en  = 1'b0;
    chk("len1_0_n", tr_n, 3);
    chk("len1_0_c", tr_c[2:0], 3'b100);
    chk("len1_0_eor", tr_e[2:0], 3'b000);
    chk("len1_0_done", tr_d[2:0], 3'b011);
    cycles(2);

    tr_en = 1'b1;
    send(0, 2);
    send(0, 4);
    cycles(4);
    tr_en = 1'b0;
    chk("b2b_n", tr_n, 8);
    chk("b2b_c", tr_c[7:0], 8'b11011110);
    chk("b2b_eor", tr_e[7:0], 8'b00100001);
    chk("b2b_done", tr_d[7:0], 8'b00100001);
    cycles(2);

    tr_sel = 1;
    tr_en  = 1'b1;
    send(1, 15);
    cycles(17);
    tr_en  = 1'b0;
    chk("g3_n", tr_n, 18);
    chk("g3_c", tr_c[17:0], 18'h3FFF8);
    chk("g3_eor", tr_e[17:0], 18'h00004);
    chk("g3_done", tr_d[17:0], 18'h00001);
    cycles(2);
    chk("g3_idle", {d_busy[1], d_rdy[1]}, 2'b01);

    tr_sel = 0;
    send(0, 15);
    cycles(4);
    chk("pre_rst_c", {d_c[0], d_busy[0]}, 2'b11);
    reset = 1'b0;
    #1;
    chk("async_rst", {d_rdy[0], d_c[0], d_busy[0], d_eor[0], d_done[0]}, 5'b10000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycles(3);
    chk("post_rst", {d_rdy[0], d_busy[0], d_done[0]}, 3'b100);

    tr_en = 1'b1;
    send(0, 2);
    cycles(2);
    tr_en = 1'b0;
    chk("post_rst_n", tr_n, 3);
    chk("post_rst_c", tr_c[2:0], 3'b110);
    chk("post_rst_eor", tr_e[2:0], 3'b001);
    chk("post_rst_done", tr_d[2:0], 3'b001);
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_burst_generator.md
# run_burst_generator

Serial run-length burst generator: the transmit-side counterpart of the team's "more than one 1" sequence detector. It accepts a run length over a valid/ready handshake, drives that many consecutive 1s on a single-bit serial line, then drives a programmable gap of 0s. It flags the end of every run of two or more 1s, on the same bit where a downstream detector fires. It is used as a stimulus and link source feeding serial sequence-detection FSMs.

## Interface
- LEN_W, 4: width of run-length field; max run = 2^LEN_W-1; must be ≥2
- GAP_LEN, 1: number of 0 bits driven after each run; must be ≥1
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clock clk
- req_valid  input  1  request present
- req_len  input  LEN_W  run length (number of 1 bits); sampled only on handshake
- req_ready  output  1  generator can accept a request this cycle
- c  output  1  serial bit stream
- busy  output  1  state != IDLE
- eor  output  1  end-of-run strobe: high on the first gap bit following a run of length ≥2
- done  output  1  high on the last gap bit of a request

## Operation
- States: IDLE, RUN, GAP.
- The following are registered: the state, a run counter (LEN_W bits), a gap counter (width clog2(GAP_LEN+1)), and a run-was-long flag.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready.
- IDLE → RUN on accept with req_len ≥1. The run counter loads req_len-1. The long flag loads (req_len ≥2).
- IDLE → GAP on accept with req_len = 0. The gap counter loads GAP_LEN-1. The long flag loads 0.
- RUN: c = 1. Decrement the run counter. When it is 0, go to GAP and load the gap counter with GAP_LEN-1.
- GAP: c = 0. Decrement the gap counter. When it is 0:
  - accept in the same cycle → RUN or GAP per the new req_len (back-to-back, no idle bit);
  - otherwise → IDLE.
- Output decode (from registered state/counters only; no combinational path from req_valid or req_len to any output):
  - req_ready = IDLE, or (GAP and gap counter = 0);
  - c = RUN;
  - busy = state != IDLE;
  - eor = GAP and gap counter = GAP_LEN-1 and long flag;
  - done = GAP and gap counter = 0.
- req_len changes while not accepted are ignored. A req_valid held in a non-ready cycle is not consumed.
- Length 0 emits only the GAP_LEN zeros, with eor = 0 and done at the end.
- Length 1 emits a single 1, then the gap, with eor = 0.
- Reset values: IDLE; c=0, req_ready=1, busy=0, eor=0, done=0; counters and long flag 0.

## Timing
- Latency: the first 1 appears on c the cycle after the accepting edge.
- A request of length N occupies exactly N+GAP_LEN cycles of c. Sustained throughput is one request per N+GAP_LEN cycles.
- eor coincides with the first 0 after the run. done and req_ready coincide on the last gap cycle.
- When GAP_LEN=1, eor and done are asserted in the same cycle.
- Reset mid-operation (any state) asynchronously forces IDLE and the reset output values. The in-flight request is dropped and no done is generated for it.
- No counter ever wraps. The run counter is loaded ≤2^LEN_W-2, and both counters only decrement to 0.

## Structure
- Package run_burst_pkg holds:
  - the state enum typedef: IDLE=2'd0, RUN=2'd1, GAP=2'd2;
  - the function computing the gap counter width.
- One sub-module, load_down_counter (parameter WIDTH; ports load, load_val, dec, zero). It is instantiated twice, for the run counter and the gap counter.
- Top-level parameter checks are elaboration-time errors for LEN_W<2 or GAP_LEN<1.

## Test plan
(LEN_W=4, GAP_LEN=1 unless noted)
- Reset held low for 3 cycles → c=0, req_ready=1, busy=0, eor=0, done=0 throughout. Release → still idle.
- Accept len=3 at edge T → c=1 at T+1..T+3. At T+4: c=0, eor=1, done=1, req_ready=1. At T+5: busy=0.
- Accept len=1, then len=0 → c = 1,0 with eor=0 and done on the 0. Then a single 0 with done=1 and eor=0.
- Back-to-back: len=2, with len=4 valid in the done cycle → c = 1,1,0,1,1,1,1,0 with no idle bit. eor pulses twice; done pulses twice.
- GAP_LEN=3, len=15:
  - c=1 for 15 cycles, then 0,0,0;
  - eor on the first 0, done and req_ready on the third 0;
  - no counter wrap.
- Reset asserted during the 5th 1 of len=15 → c drops to 0 asynchronously. After release: IDLE and req_ready=1, with no done for the dropped request. A subsequent len=2 runs normally, with eor=1.
